// File: rtl/dual_grant_pkg.sv
// dual_grant_pkg: slot state and slot payload types shared by dual_grant_sched.
package dual_grant_pkg;
   localparam int DIR_MAX = 16;
   typedef enum logic {EMPTY, OFFER} slot_st_e;
   typedef struct packed {
      logic               vld;
      logic [DIR_MAX-1:0] dir;
   } slot_t;
endpackage

// File: rtl/dual_grant_sched_pend_pick.sv
// pend_pick: highest (p1) and second-highest (p2) set bits of the pending vector.
module pend_pick #(
   parameter int N = 8
) (
   input  logic [N-1:0]         pend,
   output logic [$clog2(N)-1:0] p1,
   output logic [$clog2(N)-1:0] p2,
   output logic                 p1_v,
   output logic                 p2_v
);
   localparam int W = $clog2(N);
   logic [N-1:0] rest;
   always_comb begin
      p1   = '0;
      p1_v = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (pend[i]) begin
            p1   = W'(i);
            p1_v = 1'b1;
         end
      end
      rest = pend & ~(N'(p1_v) << p1);
      p2   = '0;
      p2_v = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (rest[i]) begin
            p2   = W'(i);
            p2_v = 1'b1;
         end
      end
   end
endmodule

// File: rtl/dual_grant_sched.sv
// dual_grant_sched: two-slot offer scheduler fed by a registered pending-request vector.
// Define DUAL_GRANT_SCHED_STATS_EN to add the grant_cnt handshake counter.
module dual_grant_sched
   import dual_grant_pkg::*;
#(
   parameter int N  = 8,
   parameter int CW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req_in,
   output logic                 vld_a,
   output logic [$clog2(N)-1:0] dir_a,
   input  logic                 rdy_a,
   output logic                 vld_b,
   output logic [$clog2(N)-1:0] dir_b,
   input  logic                 rdy_b,
   output logic [N-1:0]         pend,
`ifdef DUAL_GRANT_SCHED_STATS_EN
   output logic [CW-1:0]        grant_cnt,
`endif
   output logic                 busy
);
   localparam int W = $clog2(N);
   slot_st_e     st_a, st_b;
   slot_t        nxt_a, nxt_b;
   logic [W-1:0] p1, p2;
   logic         p1_v, p2_v, free_a, free_b, unused_ok;
   logic [N-1:0] mask;
   pend_pick #(.N(N)) u_pick (
      .pend (pend),
      .p1   (p1),
      .p2   (p2),
      .p1_v (p1_v),
      .p2_v (p2_v)
   );
   assign vld_a     = st_a == OFFER;
   assign vld_b     = st_b == OFFER;
   assign free_a    = !vld_a || rdy_a;
   assign free_b    = !vld_b || rdy_b;
   assign busy      = |pend || vld_a || vld_b;
   assign unused_ok = &{1'b0, nxt_a.dir, nxt_b.dir};
   // slot B takes p1 when A is stalled, otherwise the runner-up p2
   always_comb begin
      nxt_a = free_a ? slot_t'{vld: p1_v, dir: DIR_MAX'(p1)}
                     : slot_t'{vld: vld_a, dir: DIR_MAX'(dir_a)};
      nxt_b = !free_b ? slot_t'{vld: vld_b, dir: DIR_MAX'(dir_b)}
            : free_a  ? slot_t'{vld: p2_v, dir: DIR_MAX'(p2)}
                      : slot_t'{vld: p1_v, dir: DIR_MAX'(p1)};
      mask = '0;
      if (free_a && p1_v) mask[p1] = 1'b1;
      if (free_b && nxt_b.vld) mask[nxt_b.dir[W-1:0]] = 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pend  <= '0;
         st_a  <= EMPTY;
         st_b  <= EMPTY;
         dir_a <= '0;
         dir_b <= '0;
      end else begin
         pend  <= (pend & ~mask) | req_in;
         st_a  <= nxt_a.vld ? OFFER : EMPTY;
         st_b  <= nxt_b.vld ? OFFER : EMPTY;
         dir_a <= nxt_a.dir[W-1:0];
         dir_b <= nxt_b.dir[W-1:0];
      end
   end
`ifdef DUAL_GRANT_SCHED_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) grant_cnt <= '0;
      else grant_cnt <= grant_cnt + CW'(vld_a && rdy_a) + CW'(vld_b && rdy_b);
   end
`else
   localparam int unused_cw = CW;
`endif
endmodule
